buzzer_tone_driver: RTL
=======================

// Module: buzzer_tone_driver
// PURPOSE
//  Converts the level-type buzzer enable (beep_en, high for the beep window) into the square wave that drives the passive buzzer pin.
//  Sits between the eat-event beep timer and the board buzzer pin.
//  Every burst contains only whole tone periods, so the buzzer never gets a truncated pulse.
// PARAMETERS
//  CLK_FREQ      50_000_000  sys_clk frequency, Hz
//  TONE_HZ       2_000       primary tone, Hz; HALF1 = CLK_FREQ/(2*TONE_HZ) cycles per level
//  TONE2_HZ      3_000       secondary tone, Hz; HALF2 = CLK_FREQ/(2*TONE2_HZ) (chirp build only)
//  CHIRP_CYCLES  2_500_000   sys_clk cycles between tone swaps (chirp build only)
//  Constraint: HALF1, HALF2 >= 2. Half-period counter width = $clog2(max(HALF1,HALF2)).
// PORTS
//  sys_clk    in   1  system clock
//  sys_rst_n  in   1  asynchronous reset, active-low
//  beep_en    in   1  level request from the beep timer; high = sound
//  beep       out  1  buzzer drive, square wave; idles low
//  busy       out  1  high while state != IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, beep=0, busy=0, half_cnt=0; all chirp state cleared.
//  Reset asserted mid-burst forces beep low immediately.
//  States: IDLE, TONE, DRAIN. beep and busy are registered.
//  IDLE:
//   - beep=0.
//   - beep_en sampled 1 -> next cycle: state=TONE, beep=1, half_cnt=0, tone select=primary.
//   - Latency is 1 cycle.
//  TONE:
//   - half_cnt increments every cycle.
//   - At half_cnt==HALF-1: beep toggles and half_cnt returns to 0. Each level lasts exactly HALF cycles.
//   - beep_en sampled 0 -> state=DRAIN. Counting is unaffected (no phase break).
//  DRAIN:
//   - Counting continues.
//   - At terminal count with beep=1: beep becomes 0; stay in DRAIN.
//   - At terminal count with beep=0: state=IDLE and busy=0; beep stays 0.
//   - beep_en sampled 1 in DRAIN -> state=TONE with no phase disruption.
//   - Simultaneous beep_en=1 and terminal count with beep=0: stay in TONE; beep toggles to 1.
//  Burst length = ceil((cycles beep_en held) / (2*HALF)) whole periods; high pulses are never shortened.
//  Terminal count compares against the HALF of the currently latched tone.
// CONFIGURATION
//  Macro BUZZER_CHIRP_EN.
//  Defined:
//   - chirp_cnt counts cycles while state != IDLE.
//   - At chirp_cnt==CHIRP_CYCLES-1: chirp_cnt returns to 0 and a swap is marked pending.
//   - A pending swap toggles the latched tone (HALF1<->HALF2) at the next half-period boundary only.
//   - chirp_cnt and pending clear on entry to TONE from IDLE.
//  Not defined:
//   - Single tone HALF1 only; TONE2_HZ and CHIRP_CYCLES are unused.
//   - No chirp logic is synthesised.
// TESTING (bench params: CLK_FREQ=1000, TONE_HZ=100 -> HALF1=5; TONE2_HZ=166 -> HALF2=3; CHIRP_CYCLES=20)
//  1. Idle test: reset released, beep_en=0 for 200 cycles -> beep=0 and busy=0 throughout.
//  2. Single pulse: 1-cycle beep_en pulse in IDLE -> beep high 5 cycles, starting the cycle after; then low 5 cycles.
//     busy is high exactly 10 cycles, then IDLE.
//  3. Held request: beep_en held 25 cycles -> 3 high pulses of 5 cycles each.
//     busy falls 30 cycles after start with beep low; no pulse shorter than 5 cycles.
//  4. Re-assert in DRAIN: drop beep_en for 3 cycles inside a period, then raise it -> toggle spacing stays exactly 5 cycles.
//     busy never drops.
//  5. Async reset mid-burst: assert sys_rst_n=0 while beep=1 -> beep=0 and busy=0 immediately.
//     After release, the next beep_en restarts at phase 0.
//  6. Chirp (BUZZER_CHIRP_EN): hold beep_en 60 cycles -> levels of 5 cycles until the first boundary at or after cycle 20.
//     Levels are 3 cycles from that boundary; 5 again after the boundary following cycle 40.
//     Without the macro: 5-cycle levels throughout.

Source files
------------

// File: rtl/buzzer_tone_driver.sv
// buzzer_tone_driver
//   Turns the level-type buzzer request (beep_en, high for the whole beep
//   window) into the square wave that drives a passive buzzer pin. A burst
//   always consists of whole tone periods. A high level is never cut short,
//   and the pin always ends a burst low.
//
//   Optional feature macro: BUZZER_CHIRP_EN. When it is defined, the tone
//   alternates between TONE_HZ and TONE2_HZ every CHIRP_CYCLES cycles of
//   activity. A swap only takes effect on a half-period boundary. When the
//   macro is undefined, the driver produces TONE_HZ only.
//
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous reset, active-low
//   beep_en    in   level request, high = sound
//   beep       out  registered buzzer drive, idles low
//   busy       out  registered, high while a burst (tone or drain) is active
module buzzer_tone_driver #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int TONE_HZ      = 2_000,
  parameter int TONE2_HZ     = 3_000,
  parameter int CHIRP_CYCLES = 2_500_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic beep_en,
  output logic beep,
  output logic busy
);

  localparam int HALF1    = CLK_FREQ / (2 * TONE_HZ);
  localparam int HALF2    = CLK_FREQ / (2 * TONE2_HZ);
  localparam int HALF_MAX = (HALF1 > HALF2) ? HALF1 : HALF2;
  localparam int CNT_W    = $clog2(HALF_MAX);
  localparam logic [CNT_W-1:0] HALF1_M1 = CNT_W'(HALF1 - 1);

  // A half period shorter than 2 cycles cannot be produced by this counter.
  if (HALF1 < 2 || HALF2 < 2 || CHIRP_CYCLES < 1) begin : g_param_check
    $error("buzzer_tone_driver: HALF1/HALF2 must be >= 2 and CHIRP_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TONE  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             beep_q, beep_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
  logic [CNT_W-1:0] half_m1;
  logic             term;

`ifdef BUZZER_CHIRP_EN
  localparam int CHIRP_W = (CHIRP_CYCLES > 1) ? $clog2(CHIRP_CYCLES) : 1;
  localparam logic [CHIRP_W-1:0] CHIRP_M1 = CHIRP_W'(CHIRP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HALF2_M1 = CNT_W'(HALF2 - 1);

  logic [CHIRP_W-1:0] chirp_cnt_q, chirp_cnt_d;
  logic               pend_q, pend_d;
  logic               tone2_q, tone2_d;
  logic               chirp_wrap;
  logic               swap_now;

  // The terminal count always follows the tone that is latched now.
  assign half_m1 = tone2_q ? HALF2_M1 : HALF1_M1;
`else
  assign half_m1 = HALF1_M1;
`endif

  assign term = (half_cnt_q == half_m1);

  always_comb begin
    state_d    = state_q;
    beep_d     = beep_q;
    busy_d     = busy_q;
    half_cnt_d = half_cnt_q;
    case (state_q)
      IDLE: begin
        beep_d     = 1'b0;
        busy_d     = 1'b0;
        half_cnt_d = '0;
        if (beep_en) begin
          state_d = TONE;
          beep_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      TONE, DRAIN: begin
        // TONE and DRAIN share one free-running counter. Dropping or
        // re-raising the request therefore never breaks the phase.
        state_d = beep_en ? TONE : DRAIN;
        if (term) begin
          half_cnt_d = '0;
          if (beep_q) begin
            beep_d = 1'b0;
          end else if (beep_en) begin
            beep_d = 1'b1;
          end else begin
            // End of a whole period with no request: the burst is over.
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          half_cnt_d = half_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        beep_d     = 1'b0;
        busy_d     = 1'b0;
        half_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      beep_q     <= 1'b0;
      busy_q     <= 1'b0;
      half_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beep_q     <= beep_d;
      busy_q     <= busy_d;
      half_cnt_q <= half_cnt_d;
    end
  end

`ifdef BUZZER_CHIRP_EN
  always_comb begin
    chirp_cnt_d = chirp_cnt_q;
    pend_d      = pend_q;
    tone2_d     = tone2_q;
    chirp_wrap  = (chirp_cnt_q == CHIRP_M1);
    // A wrap that lands exactly on a boundary swaps at that same boundary.
    swap_now    = pend_q | chirp_wrap;
    if (state_q == IDLE) begin
      if (beep_en) begin
        chirp_cnt_d = '0;
        pend_d      = 1'b0;
        tone2_d     = 1'b0;
      end
    end else begin
      chirp_cnt_d = chirp_wrap ? '0 : chirp_cnt_q + CHIRP_W'(1);
      if (term) begin
        tone2_d = tone2_q ^ swap_now;
        pend_d  = 1'b0;
      end else begin
        pend_d  = swap_now;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      chirp_cnt_q <= '0;
      pend_q      <= 1'b0;
      tone2_q     <= 1'b0;
    end else begin
      chirp_cnt_q <= chirp_cnt_d;
      pend_q      <= pend_d;
      tone2_q     <= tone2_d;
    end
  end
`endif

  assign beep = beep_q;
  assign busy = busy_q;

endmodule
